regfile_mmio: RTL and testbench
===============================

// Module: regfile_mmio
// PURPOSE
//  Parametrised processor register file with memory-mapped I/O registers and exported output registers.
//  - Two combinational read ports and one synchronous write port.
//  - A contiguous window of input-mapped registers samples board inputs through synchronisers.
//  - Each input-mapped register keeps a sticky rising-edge flag that software clears by writing the register.
//  - A contiguous window of output registers is exported for display/peripheral logic.
//  - Sits between decode/writeback and the processor's top-level I/O.
// PARAMETERS
//  DATA_W       32  register width
//  ADDR_W       5   address width; depth = 2**ADDR_W
//  NUM_IO       3   number of input-mapped registers
//  IO_BASE      26  index of first input-mapped register
//  IO_W         8   input bits per input-mapped register (IO_W <= DATA_W-1)
//  SYNC_STAGES  2   synchroniser depth on io_in (>= 2)
//  NUM_OUT      8   number of exported registers
//  OUT_BASE     17  index of first exported register
//  Legality: windows lie inside [1, 2**ADDR_W-1] and do not overlap; register 0 is in neither window.
// PORTS
//  clock             in   1                 system clock; all state updates on rising edge
//  ctrl_reset        in   1                 synchronous, active-high reset
//  ctrl_writeEnable  in   1                 write strobe
//  ctrl_writeReg     in   ADDR_W            write address
//  data_writeReg     in   DATA_W            write data
//  ctrl_readRegA     in   ADDR_W            read address, port A
//  ctrl_readRegB     in   ADDR_W            read address, port B
//  data_readRegA     out  DATA_W            read data, port A (combinational)
//  data_readRegB     out  DATA_W            read data, port B (combinational)
//  io_in             in   NUM_IO*IO_W       asynchronous board inputs; channel k = bits [k*IO_W +: IO_W]
//  io_out            out  NUM_OUT*DATA_W    flat copy of registers OUT_BASE..OUT_BASE+NUM_OUT-1
//  io_event          out  NUM_IO            edge flag of each input-mapped register
// BEHAVIOUR
//  - Reset: at a clock edge with ctrl_reset=1, clear all registers, all synchroniser flops and all edge flags.
//    - Consequently io_out=0, io_event=0 and all reads return 0.
//    - Reset has priority over a simultaneous write.
//  - Register 0:
//    - Always reads 0.
//    - Writes to it are ignored.
//  - General registers (not in the input window):
//    - On each edge with ctrl_writeEnable=1, reg[ctrl_writeReg] <= data_writeReg.
//    - Output registers are ordinary writable registers.
//    - io_out reflects register contents with zero added latency (directly from the flops).
//  - Reads: data_readRegX = reg[ctrl_readRegX], combinational. Both ports may address the same register.
//  - Input-mapped register k (index IO_BASE+k):
//    - Channel k passes through SYNC_STAGES flops; call the final stage s_k.
//    - Each cycle, level field [IO_W-1:0] <= s_k, so a change on io_in first appears SYNC_STAGES+1 edges later.
//    - Bit DATA_W-1 is the edge flag.
//      - It is set on the edge where any bit of s_k goes 0->1 versus the previous cycle's s_k.
//      - It stays set until cleared.
//    - Bits [DATA_W-2:IO_W] always read 0.
//    - A processor write to IO_BASE+k clears the edge flag; the write data is discarded.
//    - If a set and a clear occur in the same cycle, set wins and the flag stays 1.
//    - io_event[k] = edge flag k.
//  - Address decode is complete: any ADDR_W value is valid, with no wrap or alias.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    - Write-to-read forwarding on both ports.
//    - When ctrl_writeEnable=1, ctrl_writeReg==ctrl_readRegX, ctrl_writeReg!=0 and the address is not input-mapped,
//      data_readRegX = data_writeReg in the same cycle.
//    - io_out is not bypassed.
//  REGFILE_BYPASS_EN undefined:
//    - Reads return the pre-write value until the edge after the write.
// TESTING
//  1. Reset then read every address on both ports -> all 0; io_out=0; io_event=0.
//  2. Write 0xDEADBEEF to r5, then read r5 on A and B -> both 0xDEADBEEF. Write 0x1 to r0 -> r0 still reads 0.
//  3. Write 0x12345678 to r17 -> io_out[31:0]=0x12345678 on the following cycle. Write r24 -> io_out[255:224] updates.
//  4. io_in channel 0 goes 0x00->0xA5 at cycle t:
//     - r26 level field = 0xA5 and r26[31]=1 from edge t+3 (SYNC_STAGES=2); io_event[0]=1.
//     - Write r26 -> flag 0, level still 0xA5.
//     - New 0->1 transition coinciding with the clearing write -> flag stays 1.
//  5. Same cycle: writeEnable=1, writeReg=9, data=0x55, readRegA=9:
//     - REGFILE_BYPASS_EN defined -> A=0x55.
//     - Undefined -> A holds the old value, then 0x55 after the edge.
//  6. ctrl_reset asserted in the same cycle as a write to r3 -> r3=0; flags and io_out also clear.

Source files
------------

// File: rtl/regfile_mmio_if.sv
// Register-file access bus: one write port and two combinational read ports.
// The core drives addresses and write data; the register file returns read data.
interface regfile_mmio_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic              ctrl_writeEnable;
   logic [ADDR_W-1:0] ctrl_writeReg;
   logic [DATA_W-1:0] data_writeReg;
   logic [ADDR_W-1:0] ctrl_readRegA;
   logic [ADDR_W-1:0] ctrl_readRegB;
   logic [DATA_W-1:0] data_readRegA;
   logic [DATA_W-1:0] data_readRegB;

   modport master (
      output ctrl_writeEnable,
      output ctrl_writeReg,
      output data_writeReg,
      output ctrl_readRegA,
      output ctrl_readRegB,
      input  data_readRegA,
      input  data_readRegB
   );

   modport slave (
      input  ctrl_writeEnable,
      input  ctrl_writeReg,
      input  data_writeReg,
      input  ctrl_readRegA,
      input  ctrl_readRegB,
      output data_readRegA,
      output data_readRegB
   );
endinterface

// File: rtl/regfile_mmio.sv
// Register file with synchronised input-mapped registers and exported outputs.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mmio #(
   parameter int DATA_W      = 32,
   parameter int ADDR_W      = 5,
   parameter int NUM_IO      = 3,
   parameter int IO_BASE     = 26,
   parameter int IO_W        = 8,
   parameter int SYNC_STAGES = 2,
   parameter int NUM_OUT     = 8,
   parameter int OUT_BASE    = 17
) (
   input  logic                      clock,
   input  logic                      ctrl_reset,
   regfile_mmio_if.slave             bus,
   input  logic [NUM_IO*IO_W-1:0]    io_in,
   output logic [NUM_OUT*DATA_W-1:0] io_out,
   output logic [NUM_IO-1:0]         io_event
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] rf [DEPTH];
   logic [IO_W-1:0]   sync [NUM_IO][SYNC_STAGES];
   logic [DATA_W-1:0] io_next [NUM_IO];
   logic [IO_W-1:0]   s_cur;
   logic [IO_W-1:0]   s_old;
   logic              clr;

   function automatic logic in_io(input logic [ADDR_W-1:0] a);
      return (int'(a) >= IO_BASE) && (int'(a) < IO_BASE + NUM_IO);
   endfunction

   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         for (int k = 0; k < NUM_IO; k++)
            for (int st = 0; st < SYNC_STAGES; st++)
               sync[k][st] <= '0;
      end else begin
         for (int k = 0; k < NUM_IO; k++) begin
            sync[k][0] <= io_in[k*IO_W +: IO_W];
            for (int st = 1; st < SYNC_STAGES; st++)
               sync[k][st] <= sync[k][st-1];
         end
      end
   end

   // The level field holds last cycle's synchroniser output, so it doubles
   // as the reference for rising-edge detection.
   always_comb begin
      s_cur = '0;
      s_old = '0;
      clr   = 1'b0;
      for (int k = 0; k < NUM_IO; k++) begin
         s_cur = sync[k][SYNC_STAGES-1];
         s_old = rf[IO_BASE+k][IO_W-1:0];
         clr   = bus.ctrl_writeEnable &&
                 (bus.ctrl_writeReg == ADDR_W'(IO_BASE + k));
         io_next[k] = '0;
         io_next[k][IO_W-1:0] = s_cur;
         io_next[k][DATA_W-1] = (|(s_cur & ~s_old)) |
                                (rf[IO_BASE+k][DATA_W-1] & ~clr);
      end
   end

   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         for (int i = 0; i < DEPTH; i++)
            rf[i] <= '0;
      end else begin
         for (int i = 1; i < DEPTH; i++)
            if (!in_io(ADDR_W'(i)) && bus.ctrl_writeEnable &&
                bus.ctrl_writeReg == ADDR_W'(i))
               rf[i] <= bus.data_writeReg;
         for (int k = 0; k < NUM_IO; k++)
            rf[IO_BASE+k] <= io_next[k];
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic fwd_ok;
   assign fwd_ok = bus.ctrl_writeEnable &&
                   (bus.ctrl_writeReg != '0) &&
                   !in_io(bus.ctrl_writeReg);

   assign bus.data_readRegA =
      (fwd_ok && bus.ctrl_writeReg == bus.ctrl_readRegA) ?
      bus.data_writeReg : rf[bus.ctrl_readRegA];
   assign bus.data_readRegB =
      (fwd_ok && bus.ctrl_writeReg == bus.ctrl_readRegB) ?
      bus.data_writeReg : rf[bus.ctrl_readRegB];
`else
   assign bus.data_readRegA = rf[bus.ctrl_readRegA];
   assign bus.data_readRegB = rf[bus.ctrl_readRegB];
`endif

   for (genvar j = 0; j < NUM_OUT; j++) begin : g_out
      assign io_out[j*DATA_W +: DATA_W] = rf[OUT_BASE+j];
   end

   for (genvar k = 0; k < NUM_IO; k++) begin : g_evt
      assign io_event[k] = rf[IO_BASE+k][DATA_W-1];
   end
endmodule

// File: tb/tb_regfile_mmio.sv
// Directed bench for regfile_mmio with a per-cycle reference model.
// Define REGFILE_BYPASS_EN on both RTL and bench to test forwarding.
module tb_regfile_mmio;
   localparam int DW   = 32;
   localparam int AW   = 5;
   localparam int NIO  = 3;
   localparam int IOB  = 26;
   localparam int IOW  = 8;
   localparam int SS   = 2;
   localparam int NOUT = 8;
   localparam int OB   = 17;

   logic                 clock = 1'b0;
   logic                 ctrl_reset;
   logic [NIO*IOW-1:0]   io_in;
   logic [NOUT*DW-1:0]   io_out;
   logic [NIO-1:0]       io_event;

   regfile_mmio_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   regfile_mmio #(
      .DATA_W(DW), .ADDR_W(AW), .NUM_IO(NIO), .IO_BASE(IOB),
      .IO_W(IOW), .SYNC_STAGES(SS), .NUM_OUT(NOUT), .OUT_BASE(OB)
   ) dut (
      .clock      (clock),
      .ctrl_reset (ctrl_reset),
      .bus        (bus),
      .io_in      (io_in),
      .io_out     (io_out),
      .io_event   (io_event)
   );

   always #5 clock = ~clock;

   logic [DW-1:0]      mem [32];
   logic [IOW-1:0]     lvl [NIO];
   logic               flg [NIO];
   logic [NIO*IOW-1:0] hist [$];
   int total  = 0;
   int passed = 0;
   bit chk_en = 1'b0;

   function automatic bit is_io(input int a);
      return a >= IOB && a < IOB + NIO;
   endfunction

   function automatic logic [DW-1:0] mread(input int a);
      logic [DW-1:0] w;
      w = '0;
      if (a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
      if (bus.ctrl_writeEnable && int'(bus.ctrl_writeReg) == a && !is_io(a))
         return bus.data_writeReg;
`endif
      if (is_io(a)) begin
         w[IOW-1:0] = lvl[a-IOB];
         w[DW-1]    = flg[a-IOB];
         return w;
      end
      return mem[a];
   endfunction

   // Reference model: behaviour of every register at each rising edge.
   always @(posedge clock) begin
      logic [NIO*IOW-1:0] s_all;
      logic [IOW-1:0] s;
      int wa;
      wa = int'(bus.ctrl_writeReg);
      if (ctrl_reset) begin
         for (int i = 0; i < 32; i++) mem[i] = '0;
         for (int k = 0; k < NIO; k++) begin
            lvl[k] = '0;
            flg[k] = 1'b0;
         end
         hist = {};
         for (int i = 0; i < SS; i++) hist.push_back('0);
      end else begin
         s_all = hist[0];
         for (int k = 0; k < NIO; k++) begin
            s = s_all[k*IOW +: IOW];
            flg[k] = ((s & ~lvl[k]) != 0) ||
                     (flg[k] && !(bus.ctrl_writeEnable && wa == IOB + k));
            lvl[k] = s;
         end
         if (bus.ctrl_writeEnable && wa != 0 && !is_io(wa))
            mem[wa] = bus.data_writeReg;
         void'(hist.pop_front());
         hist.push_back(io_in);
      end
   end

   task automatic chk(input string name, input logic [255:0] act,
                      input logic [255:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   always @(negedge clock) begin
      logic [NOUT*DW-1:0] eo;
      logic [NIO-1:0] ee;
      if (chk_en) begin
         for (int j = 0; j < NOUT; j++) eo[j*DW +: DW] = mem[OB+j];
         for (int k = 0; k < NIO; k++) ee[k] = flg[k];
         chk("cyc_rdA", bus.data_readRegA, mread(int'(bus.ctrl_readRegA)));
         chk("cyc_rdB", bus.data_readRegB, mread(int'(bus.ctrl_readRegB)));
         chk("cyc_io_out", io_out, eo);
         chk("cyc_io_event", io_event, ee);
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input int a, input logic [DW-1:0] d);
      bus.ctrl_writeEnable = 1'b1;
      bus.ctrl_writeReg    = AW'(a);
      bus.data_writeReg    = d;
      tick();
      bus.ctrl_writeEnable = 1'b0;
   endtask

   initial begin
      ctrl_reset           = 1'b1;
      bus.ctrl_writeEnable = 1'b0;
      bus.ctrl_writeReg    = '0;
      bus.data_writeReg    = '0;
      bus.ctrl_readRegA    = '0;
      bus.ctrl_readRegB    = '0;
      io_in                = '0;
      tick();
      tick();
      ctrl_reset = 1'b0;
      chk_en     = 1'b1;
      chk("rst_io_out", io_out, '0);
      chk("rst_io_event", io_event, '0);
      for (int a = 0; a < 32; a++) begin
         bus.ctrl_readRegA = AW'(a);
         bus.ctrl_readRegB = AW'(31 - a);
         #1;
         chk("rst_rdA", bus.data_readRegA, '0);
         chk("rst_rdB", bus.data_readRegB, '0);
         tick();
      end

      wr(5, 32'hDEADBEEF);
      bus.ctrl_readRegA = 5'd5;
      bus.ctrl_readRegB = 5'd5;
      #1;
      chk("r5_A", bus.data_readRegA, 32'hDEADBEEF);
      chk("r5_B", bus.data_readRegB, 32'hDEADBEEF);
      wr(0, 32'h1);
      bus.ctrl_readRegA = 5'd0;
      #1;
      chk("r0_zero", bus.data_readRegA, '0);

      wr(17, 32'h12345678);
      #1;
      chk("out_r17", io_out[31:0], 32'h12345678);
      wr(24, 32'hCAFEF00D);
      #1;
      chk("out_r24", io_out[255:224], 32'hCAFEF00D);

      bus.ctrl_readRegA = 5'd26;
      io_in[7:0] = 8'hA5;
      tick();
      tick();
      chk("io_lat2", bus.data_readRegA, '0);
      tick();
      chk("io_lat3", bus.data_readRegA, 32'h800000A5);
      chk("io_evt0", io_event, 3'b001);
      wr(26, 32'hFFFFFFFF);
      #1;
      chk("io_clr", bus.data_readRegA, 32'h000000A5);

      io_in[7:0] = 8'h00;
      tick(); tick(); tick();
      io_in[7:0] = 8'h0F;
      tick(); tick(); tick();
      chk("io_set2", bus.data_readRegA, 32'h8000000F);
      io_in[7:0] = 8'hFF;
      tick(); tick();
      wr(26, 32'h0);
      #1;
      chk("io_set_wins", bus.data_readRegA, 32'h800000FF);
      wr(26, 32'h0);
      #1;
      chk("io_clr2", bus.data_readRegA, 32'h000000FF);

      io_in[23:16] = 8'h80;
      bus.ctrl_readRegB = 5'd28;
      tick(); tick(); tick();
      chk("io_ch2", bus.data_readRegB, 32'h80000080);
      chk("io_evt2", io_event, 3'b100);

      wr(9, 32'h11);
      bus.ctrl_writeEnable = 1'b1;
      bus.ctrl_writeReg    = 5'd9;
      bus.data_writeReg    = 32'h55;
      bus.ctrl_readRegA    = 5'd9;
      #1;
`ifdef REGFILE_BYPASS_EN
      chk("byp_same", bus.data_readRegA, 32'h55);
`else
      chk("byp_same", bus.data_readRegA, 32'h11);
`endif
      tick();
      bus.ctrl_writeEnable = 1'b0;
      #1;
      chk("byp_after", bus.data_readRegA, 32'h55);

      bus.ctrl_writeEnable = 1'b1;
      bus.ctrl_writeReg    = 5'd27;
      bus.data_writeReg    = 32'hFFFF;
      bus.ctrl_readRegA    = 5'd27;
      #1;
      chk("byp_io", bus.data_readRegA, '0);
      tick();
      bus.ctrl_writeEnable = 1'b0;

      wr(3, 32'h77);
      bus.ctrl_readRegA    = 5'd3;
      ctrl_reset           = 1'b1;
      bus.ctrl_writeEnable = 1'b1;
      bus.ctrl_writeReg    = 5'd3;
      bus.data_writeReg    = 32'h99;
      tick();
      ctrl_reset           = 1'b0;
      bus.ctrl_writeEnable = 1'b0;
      #1;
      chk("rstw_r3", bus.data_readRegA, '0);
      chk("rstw_out", io_out, '0);
      chk("rstw_evt", io_event, '0);
      tick(); tick(); tick(); tick();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
